load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Multi-cycle data-memory access stage that sits directly downstream of the ALU in the RV32I core. It takes the effective address (ALU result) and store data (register file RD2) for loads and stores. It drives a request/grant/rvalid data-memory port with byte enables, and returns sign- or zero-extended load data for register write-back. It holds the core in stall until the access completes.

Parameters:
DATA_WIDTH, 32, data and address width in bits; only 32 is supported.

Ports:
clk  in  1  core clock, rising-edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  current instruction is a load or store; held stable while stall=1
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3: loads 0=LB 1=LH 2=LW 4=LBU 5=LHU; stores 0=SB 1=SH 2=SW
req_addr  in  32  effective byte address
req_wdata  in  32  store data, right-aligned
stall  out  1  freeze PC and register writes
rsp_valid  out  1  one-cycle pulse: access complete
rsp_rdata  out  32  extended load data, valid with rsp_valid on loads, 0 otherwise
access_fault  out  1  one-cycle pulse: misaligned address or illegal funct3
mem_req  out  1  memory request
mem_we  out  1  write strobe
mem_addr  out  32  word-aligned address (bits [1:0]=0)
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid; asserted at least 1 cycle after gnt
mem_rdata  in  32  read data

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset: while rst=0, state=IDLE and all outputs=0, including stall. Any outstanding transaction is abandoned.
- IDLE:
  - req_valid=1, legal and aligned: stall=1 combinationally in the same cycle. Latch we, funct3, addr[1:0], word address, be, wdata. Next state REQ.
  - req_valid=1, fault: access_fault=1 for that cycle, stall=0, no memory activity, stay IDLE. The instruction retires with no write-back.
  - Fault conditions: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0; load funct3 3/6/7; store funct3 ≥3.
- REQ: mem_req=1, with addr/we/be/wdata driven from registers and stable until gnt. stall=1. On mem_gnt: store → RESP; load → WAIT.
- WAIT: stall=1. On mem_rvalid, capture the extended data → RESP.
- RESP: rsp_valid=1, stall=0, rsp_rdata valid. Unconditionally → IDLE. The still-asserted req_valid is ignored, giving exactly one access per instruction.
- Byte enables:
  - SB: 4'b0001<<addr[1:0]
  - SH: 4'b0011<<{addr[1],1'b0}
  - SW: 4'b1111
  - Loads use the same enables.
- Store data: SB replicates byte[7:0] to all lanes; SH replicates half[15:0] to both halves; SW passes data through.
- Load extraction uses the latched addr[1:0]:
  - LB/LBU: byte lane addr[1:0].
  - LH/LHU: half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- mem_rvalid in IDLE/REQ/RESP is ignored. mem_gnt outside REQ is ignored.
- Minimum latency from req_valid accepted in IDLE (cycle 0) to rsp_valid:
  - store: cycle 2 (gnt in cycle 1)
  - load: cycle 3 (gnt cycle 1, rvalid cycle 2)
- Outputs mem_* are 0 when not in REQ, except that mem_addr/mem_be/mem_wdata may hold their last value.

Test Plan:
1. LW addr 0x100, gnt in first REQ cycle, rvalid 2 cycles later with 0xDEADBEEF → mem_addr=0x100, be=1111, we=0. stall high from cycle 0 until RESP. rsp_valid single pulse with rsp_rdata=0xDEADBEEF.
2. LB addr 0x103, mem_rdata=0x80FF0000 → rsp_rdata=0xFFFFFF80. Same with LBU → 0x00000080. LHU addr 0x102 → 0x000080FF.
3. SH addr 0x202, wdata 0x1234ABCD, gnt withheld 3 cycles → mem_req held 3+1 cycles with mem_addr=0x200, be=1100, wdata=0xABCDABCD, we=1 stable throughout. rsp_valid the cycle after gnt.
4. LW addr 0x101, then SH addr 0x201, then funct3=3 load → access_fault pulse each, mem_req never high, stall=0, rsp_valid=0.
5. rst low during WAIT → all outputs 0 immediately. rvalid after release is ignored. New LW addr 0x10 completes normally.
6. req_valid held high across two consecutive instructions (SW 0x40 then LW 0x44) → exactly two mem_req transactions, one rsp_valid per instruction, IDLE cycle between RESP and the next REQ.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage for the RV32I core.
// Takes the effective address and store data of a load/store, runs one
// request/grant/rvalid transaction on the data-memory port and returns
// sign/zero-extended load data. The core is held in stall until completion.
// Misaligned accesses and illegal funct3 values raise a one-cycle
// access_fault with no memory activity.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_we/req_funct3/req_addr/req_wdata : access request from ALU stage
//   stall, rsp_valid, rsp_rdata, access_fault      : back to the pipeline
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata       : memory request port
//   mem_gnt/mem_rvalid/mem_rdata                   : memory response port
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  access_fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-3:0] waddr_q, waddr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  misalign, bad_f3, fault, accept;
  logic [3:0]            be_new;
  logic [DATA_WIDTH-1:0] wdata_new;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [DATA_WIDTH-1:0] load_ext;

  // Fault classification of the incoming request.
  always_comb begin
    misalign = 1'b0;
    bad_f3   = 1'b0;
    case (req_funct3)
      3'd0: ;
      3'd1: misalign = req_addr[0];
      3'd2: misalign = |req_addr[1:0];
      3'd4: bad_f3   = req_we;
      3'd5: begin
        bad_f3   = req_we;
        misalign = req_addr[0];
      end
      default: bad_f3 = 1'b1;
    endcase
  end

  assign fault  = misalign | bad_f3;
  // Gated by rst so the combinational outputs are also 0 while in reset.
  assign accept = rst & (state_q == S_IDLE) & req_valid & ~fault;

  // Byte enables and lane-replicated store data; funct3[1:0] gives the size.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        be_new    = 4'b0001 << req_addr[1:0];
        wdata_new = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be_new    = 4'b0011 << {req_addr[1], 1'b0};
        wdata_new = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction from the latched byte offset.
  always_comb begin
    case (off_q)
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q[1:0])
      2'd0:    load_ext = {{24{~funct3_q[2] & lane_byte[7]}}, lane_byte};
      2'd1:    load_ext = {{16{~funct3_q[2] & lane_half[15]}}, lane_half};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    waddr_d  = waddr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          waddr_d  = req_addr[DATA_WIDTH-1:2];
          be_d     = be_new;
          wdata_d  = wdata_new;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = we_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      waddr_q  <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      waddr_q  <= waddr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign stall        = accept | (state_q == S_REQ) | (state_q == S_WAIT);
  assign access_fault = rst & (state_q == S_IDLE) & req_valid & fault;
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_rdata    = (rsp_valid && !we_q) ? rdata_q : '0;
  assign mem_req      = (state_q == S_REQ);
  assign mem_we       = mem_req & we_q;
  assign mem_addr     = mem_req ? {waddr_q, 2'b00} : '0;
  assign mem_be       = mem_req ? be_q : '0;
  assign mem_wdata    = mem_req ? wdata_q : '0;

endmodule
